octal_scan_ctrl: RTL and testbench

OCTAL_SCAN_CTRL -- requirements
Module: octal_scan_ctrl

---
 rtl/octal_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_octal_scan_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/octal_scan_ctrl.sv
// Multiplexed 3-digit octal display scanner with double-buffered value,
// frame-aligned updates and optional leading-zero blanking.
module octal_scan_ctrl #(
  parameter int PRESCALE = 50000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       LOAD,
  input  logic [7:0] VALUE,
  input  logic       BLANK_LZ,
  output logic [2:0] DIGIT,
  output logic [2:0] DIG_SEL,
  output logic       BLANK,
  output logic       SLOT_TICK,
  output logic       LOADED
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        st, st_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [1:0]    slot, slot_nx;
  logic [7:0]    dreg, dreg_nx;
  logic [7:0]    preg, preg_nx;
  logic          pend, pend_nx;
  logic [2:0]    digit_nx, sel_nx;
  logic          blank_nx, tick_nx, loaded_nx;

  function automatic logic [2:0] slot_code(input logic [7:0] d, input logic [1:0] s);
    case (s)
      2'd0:    slot_code = d[2:0];
      2'd1:    slot_code = d[5:3];
      default: slot_code = {1'b0, d[7:6]};
    endcase
  endfunction

  // Slot 1 only blanks when the more significant slot 2 is blank as well.
  function automatic logic lz_blank(input logic [7:0] d, input logic [1:0] s, input logic lz);
    case (s)
      2'd2:    lz_blank = lz && (d[7:6] == 2'd0);
      2'd1:    lz_blank = lz && (d[7:3] == 5'd0);
      default: lz_blank = 1'b0;
    endcase
  endfunction

  always_comb begin
    st_nx     = EN ? SCAN : IDLE;
    presc_nx  = '0;
    slot_nx   = 2'd0;
    dreg_nx   = dreg;
    preg_nx   = preg;
    pend_nx   = pend;
    tick_nx   = 1'b0;
    loaded_nx = 1'b0;

    if (st == IDLE) begin
      if (pend) begin
        dreg_nx   = preg;
        pend_nx   = 1'b0;
        loaded_nx = 1'b1;
      end
    end else if (EN) begin
      if (presc == PRESC_MAX) begin
        tick_nx = 1'b1;
        if (slot == 2'd2) begin
          // Frame boundary: the only point a new value may enter the display.
          if (pend) begin
            dreg_nx   = preg;
            pend_nx   = 1'b0;
            loaded_nx = 1'b1;
          end
        end else begin
          slot_nx = slot + 2'd1;
        end
      end else begin
        presc_nx = presc + 1'b1;
        slot_nx  = slot;
      end
    end

    if (LOAD) begin
      preg_nx = VALUE;
      pend_nx = 1'b1;
    end

    digit_nx = 3'd0;
    sel_nx   = 3'b111;
    blank_nx = 1'b1;
    if (st_nx == SCAN && !lz_blank(dreg_nx, slot_nx, BLANK_LZ)) begin
      digit_nx = slot_code(dreg_nx, slot_nx);
      sel_nx   = ~(3'b001 << slot_nx);
      blank_nx = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      st        <= IDLE;
      presc     <= '0;
      slot      <= 2'd0;
      dreg      <= 8'd0;
      preg      <= 8'd0;
      pend      <= 1'b0;
      DIGIT     <= 3'd0;
      DIG_SEL   <= 3'b111;
      BLANK     <= 1'b1;
      SLOT_TICK <= 1'b0;
      LOADED    <= 1'b0;
    end else begin
      st        <= st_nx;
      presc     <= presc_nx;
      slot      <= slot_nx;
      dreg      <= dreg_nx;
      preg      <= preg_nx;
      pend      <= pend_nx;
      DIGIT     <= digit_nx;
      DIG_SEL   <= sel_nx;
      BLANK     <= blank_nx;
      SLOT_TICK <= tick_nx;
      LOADED    <= loaded_nx;
    end
  end

endmodule

// File: tb/tb_octal_scan_ctrl.sv
// Directed, table-driven bench for octal_scan_ctrl (PRESCALE=4 main instance,
// PRESCALE=1 secondary instance).
module tb_octal_scan_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N, EN, LOAD, BLANK_LZ;
  logic [7:0] VALUE;
  logic [2:0] DIGIT, DIG_SEL;
  logic       BLANK, SLOT_TICK, LOADED;

  logic       rst1_n, en1, load1, lz1;
  logic [7:0] val1;
  logic [2:0] digit1, sel1;
  logic       blank1, tick1, loaded1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  octal_scan_ctrl #(.PRESCALE(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .LOAD(LOAD), .VALUE(VALUE),
    .BLANK_LZ(BLANK_LZ), .DIGIT(DIGIT), .DIG_SEL(DIG_SEL), .BLANK(BLANK),
    .SLOT_TICK(SLOT_TICK), .LOADED(LOADED)
  );

  octal_scan_ctrl #(.PRESCALE(1)) dut1 (
    .CLK(CLK), .RST_N(rst1_n), .EN(en1), .LOAD(load1), .VALUE(val1),
    .BLANK_LZ(lz1), .DIGIT(digit1), .DIG_SEL(sel1), .BLANK(blank1),
    .SLOT_TICK(tick1), .LOADED(loaded1)
  );

  typedef struct {
    logic       en;
    logic       load;
    logic [7:0] value;
    logic       lz;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Packed view: {DIGIT, DIG_SEL, BLANK, SLOT_TICK, LOADED}
  function automatic logic [8:0] pk(input logic [2:0] dig, input logic [2:0] sel,
                                    input logic bl, input logic tk, input logic lo);
    return {dig, sel, bl, tk, lo};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got dig/sel/blank/tick/loaded=%b required %b", name, act, exp);
    end
  endtask

  // n cycles with the same inputs; tick, loaded and load apply to the first only.
  task automatic add(input int n, input logic en, input logic ld, input logic [7:0] val,
                     input logic lz, input logic [2:0] dig, input logic [2:0] sel,
                     input logic bl, input logic tk, input logic lo);
    for (int k = 0; k < n; k++) begin
      vec_t v;
      v.en    = en;
      v.load  = (k == 0) ? ld : 1'b0;
      v.value = val;
      v.lz    = lz;
      v.exp   = pk(dig, sel, bl, (k == 0) ? tk : 1'b0, (k == 0) ? lo : 1'b0);
      vecs.push_back(v);
    end
  endtask

  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b1; LOAD = 1'b1; VALUE = 8'hFF; BLANK_LZ = 1'b0;
    rst1_n = 1'b0; en1 = 1'b0; load1 = 1'b0; val1 = 8'h00; lz1 = 1'b0;

    // Reset overrides LOAD and EN
    cyc;
    check("reset_edge1", {DIGIT, DIG_SEL, BLANK, SLOT_TICK, LOADED}, pk(0, 3'b111, 1, 0, 0));
    LOAD = 1'b0;
    cyc;
    check("reset_edge2", {DIGIT, DIG_SEL, BLANK, SLOT_TICK, LOADED}, pk(0, 3'b111, 1, 0, 0));
    RST_N = 1'b1; EN = 1'b0;
    cyc;
    check("reset_no_loaded", {DIGIT, DIG_SEL, BLANK, SLOT_TICK, LOADED}, pk(0, 3'b111, 1, 0, 0));

    // 8'hBD = octal 275: load in IDLE, then scan
    add(1, 0, 1, 8'hBD, 0, 0, 3'b111, 1, 0, 0);
    add(1, 0, 0, 8'h00, 0, 0, 3'b111, 1, 0, 1);
    add(4, 1, 0, 8'h00, 0, 5, 3'b110, 0, 0, 0);
    add(4, 1, 0, 8'h00, 0, 7, 3'b101, 0, 1, 0);
    add(4, 1, 0, 8'h00, 0, 2, 3'b011, 0, 1, 0);
    // LOAD 8'h3F mid slot 1 appears only at the next frame
    add(4, 1, 0, 8'h00, 0, 5, 3'b110, 0, 1, 0);
    add(1, 1, 0, 8'h00, 0, 7, 3'b101, 0, 1, 0);
    add(3, 1, 1, 8'h3F, 0, 7, 3'b101, 0, 0, 0);
    add(4, 1, 0, 8'h00, 0, 2, 3'b011, 0, 1, 0);
    add(4, 1, 0, 8'h00, 0, 7, 3'b110, 0, 1, 1);
    add(4, 1, 0, 8'h00, 0, 7, 3'b101, 0, 1, 0);
    add(4, 1, 0, 8'h00, 0, 0, 3'b011, 0, 1, 0);
    // Two LOADs in one frame: last wins, one LOADED
    add(1, 1, 0, 8'h00, 0, 7, 3'b110, 0, 1, 0);
    add(1, 1, 1, 8'h01, 0, 7, 3'b110, 0, 0, 0);
    add(2, 1, 1, 8'h02, 0, 7, 3'b110, 0, 0, 0);
    add(4, 1, 0, 8'h00, 0, 7, 3'b101, 0, 1, 0);
    add(4, 1, 0, 8'h00, 0, 0, 3'b011, 0, 1, 0);
    add(4, 1, 0, 8'h00, 0, 2, 3'b110, 0, 1, 1);
    // LOAD 8'h0C in slot 1, then LOAD 8'h05 exactly at the frame boundary
    add(1, 1, 0, 8'h00, 0, 0, 3'b101, 0, 1, 0);
    add(3, 1, 1, 8'h0C, 0, 0, 3'b101, 0, 0, 0);
    add(4, 1, 0, 8'h00, 0, 0, 3'b011, 0, 1, 0);
    add(4, 1, 1, 8'h05, 1, 4, 3'b110, 0, 1, 1);
    add(4, 1, 0, 8'h00, 1, 1, 3'b101, 0, 1, 0);
    add(4, 1, 0, 8'h00, 1, 0, 3'b111, 1, 1, 0);
    // 8'h05 with blanking: only slot 0 lit
    add(4, 1, 0, 8'h00, 1, 5, 3'b110, 0, 1, 1);
    add(4, 1, 0, 8'h00, 1, 0, 3'b111, 1, 1, 0);
    add(4, 1, 0, 8'h00, 1, 0, 3'b111, 1, 1, 0);
    add(4, 1, 0, 8'h00, 0, 5, 3'b110, 0, 1, 0);
    add(4, 1, 0, 8'h00, 0, 0, 3'b101, 0, 1, 0);
    add(4, 1, 0, 8'h00, 0, 0, 3'b011, 0, 1, 0);
    // EN dropped mid slot 1, then restart from slot 0 prescaler 0
    add(4, 1, 0, 8'h00, 0, 5, 3'b110, 0, 1, 0);
    add(1, 1, 0, 8'h00, 0, 0, 3'b101, 0, 1, 0);
    add(2, 0, 0, 8'h00, 0, 0, 3'b111, 1, 0, 0);
    add(4, 1, 0, 8'h00, 0, 5, 3'b110, 0, 0, 0);
    add(1, 1, 0, 8'h00, 0, 0, 3'b101, 0, 1, 0);

    foreach (vecs[i]) begin
      EN = vecs[i].en; LOAD = vecs[i].load; VALUE = vecs[i].value; BLANK_LZ = vecs[i].lz;
      cyc;
      check($sformatf("vec%0d", i), {DIGIT, DIG_SEL, BLANK, SLOT_TICK, LOADED}, vecs[i].exp);
    end

    // Mid-scan reset discards a pending value
    EN = 1'b1; LOAD = 1'b1; VALUE = 8'h77;
    cyc;
    check("pre_reset_slot1", {DIGIT, DIG_SEL, BLANK, SLOT_TICK, LOADED}, pk(0, 3'b101, 0, 0, 0));
    RST_N = 1'b0; VALUE = 8'hAA;
    cyc;
    check("midscan_reset1", {DIGIT, DIG_SEL, BLANK, SLOT_TICK, LOADED}, pk(0, 3'b111, 1, 0, 0));
    cyc;
    check("midscan_reset2", {DIGIT, DIG_SEL, BLANK, SLOT_TICK, LOADED}, pk(0, 3'b111, 1, 0, 0));
    RST_N = 1'b1; LOAD = 1'b0;
    cyc;
    check("release_slot0", {DIGIT, DIG_SEL, BLANK, SLOT_TICK, LOADED}, pk(0, 3'b110, 0, 0, 0));
    cyc;
    check("release_nopend", {DIGIT, DIG_SEL, BLANK, SLOT_TICK, LOADED}, pk(0, 3'b110, 0, 0, 0));

    // PRESCALE=1: one slot per cycle, tick held high while scanning
    rst1_n = 1'b1; load1 = 1'b1; val1 = 8'hBD;
    cyc;
    check("p1_load", {digit1, sel1, blank1, tick1, loaded1}, pk(0, 3'b111, 1, 0, 0));
    load1 = 1'b0;
    cyc;
    check("p1_loaded", {digit1, sel1, blank1, tick1, loaded1}, pk(0, 3'b111, 1, 0, 1));
    en1 = 1'b1;
    cyc;
    check("p1_slot0", {digit1, sel1, blank1, tick1, loaded1}, pk(5, 3'b110, 0, 0, 0));
    cyc;
    check("p1_slot1", {digit1, sel1, blank1, tick1, loaded1}, pk(7, 3'b101, 0, 1, 0));
    cyc;
    check("p1_slot2", {digit1, sel1, blank1, tick1, loaded1}, pk(2, 3'b011, 0, 1, 0));
    cyc;
    check("p1_wrap", {digit1, sel1, blank1, tick1, loaded1}, pk(5, 3'b110, 0, 1, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
